// File: rtl/reg_file.sv
// Integer register file feeding the ALU: two combinational read ports, one
// synchronous write-back port, optional write-to-read bypass, hardwired x0
// and a per-register busy scoreboard that flags RAW hazards to decode.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   rs1_addr_i/rs1_data_o   read port 1 (ALU operand a)
//   rs2_addr_i/rs2_data_o   read port 2 (ALU operand b)
//   we_i, rd_addr_i,
//   rd_data_i               write-back port (ALU result)
//   issue_i, issue_rd_i     destination of an instruction issued this cycle
//   hazard_o                rs1 or rs2 still awaiting write-back
module reg_file #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [(NREGS > 1 ? $clog2(NREGS) : 1)-1:0] rs1_addr_i,
    input  logic [(NREGS > 1 ? $clog2(NREGS) : 1)-1:0] rs2_addr_i,
    output logic [XLEN-1:0]                          rs1_data_o,
    output logic [XLEN-1:0]                          rs2_data_o,
    input  logic                                     we_i,
    input  logic [(NREGS > 1 ? $clog2(NREGS) : 1)-1:0] rd_addr_i,
    input  logic [XLEN-1:0]                          rd_data_i,
    input  logic                                     issue_i,
    input  logic [(NREGS > 1 ? $clog2(NREGS) : 1)-1:0] issue_rd_i,
    output logic                                     hazard_o
);

    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_ok;
    logic             iss_ok;

    // Address names a real, writable register (not x0, not past NREGS).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    // Same-cycle write-back to this address is visible on the read side.
    function automatic logic fwd_hit(input logic [AW-1:0] a);
        return BYPASS && we_i && (rd_addr_i == a);
    endfunction

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        logic [XLEN-1:0] d;
        d = '0;
        if (addr_ok(a)) begin
            d = fwd_hit(a) ? rd_data_i : regs[a];
        end
        return d;
    endfunction

    function automatic logic pend(input logic [AW-1:0] a);
        return addr_ok(a) && busy[a] && !fwd_hit(a);
    endfunction

    assign wr_ok  = we_i && addr_ok(rd_addr_i);
    assign iss_ok = issue_i && addr_ok(issue_rd_i);

    // Read ports and hazard detection.
    always_comb begin
        rs1_data_o = read_port(rs1_addr_i);
        rs2_data_o = read_port(rs2_addr_i);
        hazard_o   = pend(rs1_addr_i) || pend(rs2_addr_i);
    end

    // Scoreboard next state: clear on write-back, then set on issue so a new
    // producer of the same register stays outstanding.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[rd_addr_i] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[issue_rd_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Register array and scoreboard state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_ok) begin
                regs[rd_addr_i] <= rd_data_i;
            end
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    logic            clk_i;
    logic            rst_ni;
    logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr, issue_rd;
    logic            we, issue;
    logic [XLEN-1:0] rd_data;

    logic [XLEN-1:0] b1_rs1, b1_rs2, b0_rs1, b0_rs2;
    logic            b1_hz, b0_hz;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: architectural values and outstanding destinations.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    reg_file #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b1)) u_byp (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_data_o(b1_rs1), .rs2_data_o(b1_rs2),
        .we_i(we), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
        .issue_i(issue), .issue_rd_i(issue_rd), .hazard_o(b1_hz)
    );

    reg_file #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1'b0)) u_nobyp (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rs1_data_o(b0_rs1), .rs2_data_o(b0_rs2),
        .we_i(we), .rd_addr_i(rd_addr), .rd_data_i(rd_data),
        .issue_i(issue), .issue_rd_i(issue_rd), .hazard_o(b0_hz)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we && rd_addr == a) return rd_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_hazard(input bit byp);
        bit p1, p2;
        p1 = (rs1_addr != 0) && m_busy[rs1_addr] && !(byp && we && rd_addr == rs1_addr);
        p2 = (rs2_addr != 0) && m_busy[rs2_addr] && !(byp && we && rd_addr == rs2_addr);
        return p1 | p2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Let inputs settle and compare every output of both instances with the model.
    task automatic settle_check(input string tag);
        #1;
        chk({tag, ".b1.rs1"}, b1_rs1, exp_read(rs1_addr, 1'b1));
        chk({tag, ".b1.rs2"}, b1_rs2, exp_read(rs2_addr, 1'b1));
        chk({tag, ".b1.hz"}, 32'(b1_hz), 32'(exp_hazard(1'b1)));
        chk({tag, ".b0.rs1"}, b0_rs1, exp_read(rs1_addr, 1'b0));
        chk({tag, ".b0.rs2"}, b0_rs2, exp_read(rs2_addr, 1'b0));
        chk({tag, ".b0.hz"}, 32'(b0_hz), 32'(exp_hazard(1'b0)));
    endtask

    // Clock edge; model commits the same edge, then return at the next falling edge.
    task automatic advance();
        @(posedge clk_i);
        if (rst_ni) begin
            if (we && rd_addr != 0) begin
                m_regs[rd_addr] = rd_data;
                m_busy[rd_addr] = 1'b0;
            end
            if (issue && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        @(negedge clk_i);
    endtask

    task automatic idle();
        we = 1'b0; issue = 1'b0; rd_addr = '0; issue_rd = '0; rd_data = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        settle_check("reset");
        chk("reset.rs1", b1_rs1, 32'h0);
        chk("reset.hz", 32'(b1_hz), 32'h0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // x0 is hardwired
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'h12345678;
        settle_check("x0.wr");
        advance();
        idle(); issue = 1'b1; issue_rd = 5'd0;
        settle_check("x0.rd");
        chk("x0.rs1", b1_rs1, 32'h0);
        advance();
        idle();
        settle_check("x0.hz");
        chk("x0.hz", 32'(b1_hz), 32'h0);

        // write then read, with and without bypass
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'hA5A5A5A5; rs2_addr = 5'd7;
        settle_check("wr7.same");
        chk("wr7.same.byp", b1_rs2, 32'hA5A5A5A5);
        chk("wr7.same.nobyp", b0_rs2, 32'h0);
        advance();
        idle(); rs2_addr = 5'd7;
        settle_check("wr7.next");
        chk("wr7.next.byp", b1_rs2, 32'hA5A5A5A5);
        chk("wr7.next.nobyp", b0_rs2, 32'hA5A5A5A5);
        advance();

        // RAW hazard on x3
        idle(); issue = 1'b1; issue_rd = 5'd3;
        settle_check("raw.issue");
        advance();
        idle(); rs1_addr = 5'd3;
        settle_check("raw.wait0");
        chk("raw.wait0.hz", 32'(b1_hz), 32'h1);
        advance();
        settle_check("raw.wait1");
        we = 1'b1; rd_addr = 5'd3; rd_data = 32'h42;
        settle_check("raw.wb");
        chk("raw.wb.byp.hz", 32'(b1_hz), 32'h0);
        chk("raw.wb.byp.rs1", b1_rs1, 32'h42);
        chk("raw.wb.nobyp.hz", 32'(b0_hz), 32'h1);
        advance();
        idle(); rs1_addr = 5'd3;
        settle_check("raw.after");
        chk("raw.after.nobyp.hz", 32'(b0_hz), 32'h0);
        chk("raw.after.nobyp.rs1", b0_rs1, 32'h42);
        advance();

        // issue and write-back collide on x9
        idle(); issue = 1'b1; issue_rd = 5'd9;
        advance();
        issue = 1'b1; issue_rd = 5'd9; we = 1'b1; rd_addr = 5'd9; rd_data = 32'h77;
        settle_check("coll.edge");
        advance();
        idle(); rs2_addr = 5'd9;
        settle_check("coll.after");
        chk("coll.busy9", 32'(b0_hz), 32'h1);
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'h99;
        advance();

        // both ports on the same register
        idle(); we = 1'b1; rd_addr = 5'd12; rd_data = 32'hFFFFFFFF;
        advance();
        idle(); rs1_addr = 5'd12; rs2_addr = 5'd12;
        settle_check("dual");
        chk("dual.b1.rs1", b1_rs1, 32'hFFFFFFFF);
        chk("dual.b0.rs2", b0_rs2, 32'hFFFFFFFF);
        advance();

        // random traffic, addresses biased toward a few registers for collisions
        for (int i = 0; i < 400; i++) begin
            rs1_addr = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 6));
            rs2_addr = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 6));
            we       = 1'($urandom_range(0, 1));
            rd_addr  = 5'($urandom_range(0, 6));
            rd_data  = $urandom;
            issue    = ($urandom_range(0, 2) == 0);
            issue_rd = 5'($urandom_range(0, 6));
            settle_check("rand");
            advance();
        end

        // reset mid-run discards data and busy bits; no write while held
        idle(); we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF; issue = 1'b1; issue_rd = 5'd6;
        advance();
        idle(); rs1_addr = 5'd5; rs2_addr = 5'd6;
        settle_check("pre.rst");
        chk("pre.rst.x5", b1_rs1, 32'hDEADBEEF);
        rst_ni = 1'b0;
        model_reset();
        settle_check("mid.rst");
        chk("mid.rst.x5", b1_rs1, 32'h0);
        chk("mid.rst.hz", 32'(b1_hz), 32'h0);
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'h11111111; issue = 1'b1; issue_rd = 5'd5;
        advance();
        idle(); rs1_addr = 5'd5; rs2_addr = 5'd6;
        rst_ni = 1'b1;
        settle_check("post.rst");
        chk("post.rst.x5", b0_rs1, 32'h0);
        chk("post.rst.hz", 32'(b0_hz), 32'h0);
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
